dcm_supervisor: RTL and testbench

- Sequences the Spartan-3 clock-synthesis DCM through reset and lock acquisition, then watches it during operation.
- Drives the DCM reset, qualifies LOCKED and STATUS, retries on failure and gates the system reset until the synthesized clock is proven stable.
- Runs on the free-running board input clock, ahead of every block clocked by CLKFX.

---
 rtl/dcm_sup_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/dcm_supervisor.sv | 162 ++++++++++++++++
 tb/tb_dcm_supervisor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dcm_sup_pkg.sv
// rtl/dcm_sup_pkg.sv - shared types and constants for the DCM supervisor
// Purpose: state encoding and DCM STATUS bit positions used by dcm_supervisor.
// Ports: none (package).
package dcm_sup_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int STATUS_CLKIN_STOP = 1;
    localparam int STATUS_CLKFX_STOP = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer bank with synchronous reset
// Purpose: brings asynchronous level signals into the clk domain.
// Ports:
//   clk  in  sampling clock
//   rst  in  synchronous active-high reset, clears both stages to 0
//   d    in  asynchronous inputs
//   q    out synchronized outputs (2 clk edges of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_supervisor.sv
// rtl/dcm_supervisor.sv - DCM reset/lock sequencer and run-time watchdog
// Purpose: pulses DCM_RST, waits for a qualified lock, holds SYS_RST until
// lock has been continuous for STABLE_CYCLES, watches for loss in RUN and
// retries up to RETRY_MAX times before latching FAULT.
// Ports:
//   CLKIN       in  free-running board clock (also feeds DCM CLKIN)
//   RST         in  synchronous active-high reset
//   DCM_LOCKED  in  DCM LOCKED, asynchronous
//   DCM_STATUS  in  DCM STATUS[7:0], bit1 CLKIN stopped, bit2 CLKFX stopped
//   DCM_RST     out DCM reset
//   SYS_RST     out reset for the CLKFX domain
//   CLK_GOOD    out high only in RUN
//   FAULT       out retries exhausted
//   RETRY_CNT   out failed attempts since last RUN entry
//   LOSS_CNT    out saturating count of RUN exits since RST
module dcm_supervisor
    import dcm_sup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int STABLE_CYCLES   = 1024,
    parameter int RETRY_MAX       = 3,
    parameter int CNT_W           = 16
) (
    input  logic       CLKIN,
    input  logic       RST,
    input  logic       DCM_LOCKED,
    input  logic [7:0] DCM_STATUS,
    output logic       DCM_RST,
    output logic       SYS_RST,
    output logic       CLK_GOOD,
    output logic       FAULT,
    output logic [2:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(RETRY_MAX);

    logic [2:0] sync_in;
    logic [2:0] sync_out;
    logic       lk;
    logic       inst;
    logic       fxst;

    // Remaining STATUS bits carry nothing the supervisor acts on.
    logic unused_status;
    assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[0]};

    assign sync_in = {DCM_STATUS[STATUS_CLKFX_STOP],
                      DCM_STATUS[STATUS_CLKIN_STOP],
                      DCM_LOCKED};

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk (CLKIN),
        .rst (RST),
        .d   (sync_in),
        .q   (sync_out)
    );

    assign lk   = sync_out[0];
    assign inst = sync_out[1];
    assign fxst = sync_out[2];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_d;
    logic [7:0]       loss_d;
    logic             fail;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = RETRY_CNT;
        loss_d  = LOSS_CNT;
        fail    = 1'b0;

        case (state_q)
            S_RESET: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (lk && !fxst) begin
                    cnt_d   = '0;
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk || fxst) begin
                    fail = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    retry_d = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // inst is only trusted here; the DCM flags it spuriously in reset.
                if (!lk || fxst || inst) begin
                    if (LOSS_CNT != 8'hFF) begin
                        loss_d = LOSS_CNT + 8'd1;
                    end
                    fail = 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_RESET;
            end
        endcase

        if (fail) begin
            if (RETRY_CNT == RETRY_LIMIT) begin
                state_d = S_FAULT;
            end else begin
                retry_d = RETRY_CNT + 3'd1;
                cnt_d   = '0;
                state_d = S_RESET;
            end
        end
    end

    // Outputs decode state_d so they move on the same edge as the state.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            DCM_RST   <= 1'b1;
            SYS_RST   <= 1'b1;
            CLK_GOOD  <= 1'b0;
            FAULT     <= 1'b0;
            RETRY_CNT <= '0;
            LOSS_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            RETRY_CNT <= retry_d;
            LOSS_CNT  <= loss_d;
            DCM_RST   <= (state_d == S_RESET) || (state_d == S_FAULT);
            SYS_RST   <= (state_d != S_RUN);
            CLK_GOOD  <= (state_d == S_RUN);
            FAULT     <= (state_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_dcm_supervisor.sv
// tb/tb_dcm_supervisor.sv - self-checking bench for dcm_supervisor
module tb_dcm_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic [7:0] status;
    logic       dcm_rst;
    logic       sys_rst;
    logic       clk_good;
    logic       fault;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dcm_supervisor #(
        .RST_HOLD_CYCLES (4),
        .LOCK_TIMEOUT    (100),
        .STABLE_CYCLES   (16),
        .RETRY_MAX       (3),
        .CNT_W           (16)
    ) dut (
        .CLKIN      (clk),
        .RST        (rst),
        .DCM_LOCKED (locked),
        .DCM_STATUS (status),
        .DCM_RST    (dcm_rst),
        .SYS_RST    (sys_rst),
        .CLK_GOOD   (clk_good),
        .FAULT      (fault),
        .RETRY_CNT  (retry_cnt),
        .LOSS_CNT   (loss_cnt)
    );

    typedef struct {
        logic       rst;
        logic       lk;
        logic [7:0] st;
        int         n;
        logic       dcm_rst;
        logic       sys_rst;
        logic       clk_good;
        logic       fault;
        logic [2:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input string name, input int budget);
        int k;
        k = 0;
        while (clk_good !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, clk_good}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst lk st n : dcm_rst sys_rst clk_good fault retry loss
        // clean bring-up: DCM_RST 4 cycles, lock at cycle 20, RUN 19 edges later
        vecs.push_back('{1, 0, 8'h00,   2, 1, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 0, 8'h00,   3, 1, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 0, 8'h00,   1, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 0, 8'h00,  16, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  18, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 0, 1, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  50, 0, 0, 1, 0, 3'd0, 8'd0});
        // one-cycle CLKFX-stopped in RUN: reacts on the 3rd edge
        vecs.push_back('{0, 1, 8'h04,   1, 0, 0, 1, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 0, 1, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 1, 1, 0, 0, 3'd1, 8'd1});
        vecs.push_back('{0, 1, 8'h00,   3, 1, 1, 0, 0, 3'd1, 8'd1});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 1, 0, 0, 3'd1, 8'd1});
        vecs.push_back('{0, 1, 8'h00,  16, 0, 1, 0, 0, 3'd1, 8'd1});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 0, 1, 0, 3'd0, 8'd1});
        // reset from RUN, then glitch in STABLE at count 10
        vecs.push_back('{1, 1, 8'h00,   1, 1, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  13, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 0, 8'h00,   1, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 1, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   4, 0, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  16, 0, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 1, 8'h00,   1, 0, 0, 1, 0, 3'd0, 8'd0});
        // reset during STABLE
        vecs.push_back('{1, 1, 8'h00,   1, 1, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  13, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{1, 1, 8'h00,   1, 1, 1, 0, 0, 3'd0, 8'd0});
        // lock timeout every 104 cycles, FAULT after 4th, reset out of FAULT
        vecs.push_back('{0, 0, 8'h06, 103, 0, 1, 0, 0, 3'd0, 8'd0});
        vecs.push_back('{0, 0, 8'h02,   1, 1, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 0, 8'h00,   3, 1, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 0, 8'h00,   1, 0, 1, 0, 0, 3'd1, 8'd0});
        vecs.push_back('{0, 0, 8'h00, 100, 1, 1, 0, 0, 3'd2, 8'd0});
        vecs.push_back('{0, 0, 8'h00, 104, 1, 1, 0, 0, 3'd3, 8'd0});
        vecs.push_back('{0, 0, 8'h00, 104, 1, 1, 0, 1, 3'd3, 8'd0});
        vecs.push_back('{0, 1, 8'h00,  50, 1, 1, 0, 1, 3'd3, 8'd0});
        vecs.push_back('{1, 1, 8'h00,   1, 1, 1, 0, 0, 3'd0, 8'd0});

        rst    = 1'b1;
        locked = 1'b0;
        status = 8'h00;

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            locked = vecs[i].lk;
            status = vecs[i].st;
            tick(vecs[i].n);
            check($sformatf("v%0d.dcm_rst", i),   {31'd0, dcm_rst},   {31'd0, vecs[i].dcm_rst});
            check($sformatf("v%0d.sys_rst", i),   {31'd0, sys_rst},   {31'd0, vecs[i].sys_rst});
            check($sformatf("v%0d.clk_good", i),  {31'd0, clk_good},  {31'd0, vecs[i].clk_good});
            check($sformatf("v%0d.fault", i),     {31'd0, fault},     {31'd0, vecs[i].fault});
            check($sformatf("v%0d.retry_cnt", i), {29'd0, retry_cnt}, {29'd0, vecs[i].retry});
            check($sformatf("v%0d.loss_cnt", i),  {24'd0, loss_cnt},  {24'd0, vecs[i].loss});
        end

        // LOSS_CNT saturation: 260 RUN losses, each followed by relock
        rst    = 1'b0;
        locked = 1'b1;
        status = 8'h00;
        wait_run("sat.first_run", 60);
        for (int i = 0; i < 260; i++) begin
            status = 8'h04;
            tick(1);
            status = 8'h00;
            tick(2);
            check($sformatf("sat%0d.loss_cnt", i), {24'd0, loss_cnt},
                  (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            check($sformatf("sat%0d.clk_good", i), {31'd0, clk_good}, 32'd0);
            wait_run($sformatf("sat%0d.relock", i), 60);
        end
        check("sat.fault", {31'd0, fault}, 32'd0);
        check("sat.retry_cnt", {29'd0, retry_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
